// File: rtl/rv32i_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : rv32i_lsu_pkg
// Description : Shared types, funct3 codes and store-lane helper for the
//               memory-stage load/store unit.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32i_lsu_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      DONE = 2'd2
   } lsu_state_t;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Returns {byte_en, wdata}. Size comes from funct3[1:0], so unsigned loads
   // share the lane pattern of their signed counterparts.
   function automatic logic [35:0] store_lanes(input logic [2:0]  funct3,
                                               input logic [1:0]  addr,
                                               input logic [31:0] wd);
      logic [3:0]  w_be;
      logic [31:0] w_wdata;
      case (funct3[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr;
            w_wdata = {4{wd[7:0]}};
         end
         2'b01: begin
            w_be    = addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{wd[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wd;
         end
      endcase
      return {w_be, w_wdata};
   endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Selects the addressed byte/half of a bus read word and
//               sign- or zero-extends it according to funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
   import rv32i_lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [2:0]  i_funct3,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection followed by extension.
   always_comb begin
      w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
      case (i_funct3)
         F3_B:    o_data = {{24{w_byte[7]}}, w_byte};
         F3_H:    o_data = {{16{w_half[15]}}, w_half};
         F3_BU:   o_data = {24'd0, w_byte};
         F3_HU:   o_data = {16'd0, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage load/store unit. Checks legality of the M-stage
//               access, runs one req/ack bus transaction, returns extended
//               load data and stalls the pipeline while the access is open.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu
   import rv32i_lsu_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        sync_reset,
   input  logic        mem_read_M,
   input  logic        mem_write_M,
   input  logic [2:0]  funct3_M,
   input  logic [31:0] ALU_result_M,
   input  logic [31:0] write_data_M,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   output logic [3:0]  bus_byte_en,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata,
   output logic [31:0] load_data_M,
   output logic        stall_M,
   output logic        misaligned_M,
   output logic        access_fault_M,
   output logic        bus_err_M
);

   localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [CNT_W:0] C_TMO = (CNT_W + 1)'(TIMEOUT_CYCLES);

   lsu_state_t       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_funct3;
   logic [1:0]       r_addr_lo;
   logic             r_is_load;

   logic        w_access;
   logic        w_f3_ok;
   logic        w_aligned;
   logic        w_fault;
   logic        w_misal;
   logic        w_legal;
   logic [35:0] w_lanes;
   logic [31:0] w_load_data;
   logic [CNT_W:0] w_cnt_inc;
   logic        w_timeout;

   // Legality decode of the access currently presented by the E->M register.
   always_comb begin
      w_access = mem_read_M | mem_write_M;
      if (mem_write_M)
         w_f3_ok = (funct3_M == F3_B) || (funct3_M == F3_H) || (funct3_M == F3_W);
      else
         w_f3_ok = (funct3_M == F3_B) || (funct3_M == F3_H) || (funct3_M == F3_W) ||
                   (funct3_M == F3_BU) || (funct3_M == F3_HU);
      case (funct3_M[1:0])
         2'b01:   w_aligned = ~ALU_result_M[0];
         2'b10:   w_aligned = (ALU_result_M[1:0] == 2'b00);
         default: w_aligned = 1'b1;
      endcase
      // Fault outranks misalignment.
      w_fault   = w_access & ((mem_read_M & mem_write_M) | ~w_f3_ok);
      w_misal   = w_access & ~w_fault & ~w_aligned;
      w_legal   = w_access & ~w_fault & w_aligned;
      w_lanes   = store_lanes(funct3_M, ALU_result_M[1:0], write_data_M);
      w_cnt_inc = {1'b0, r_cnt} + {{CNT_W{1'b0}}, 1'b1};
      w_timeout = (TIMEOUT_CYCLES != 0) && (w_cnt_inc >= C_TMO);
      stall_M   = sync_reset & ((r_state == REQ) | ((r_state == IDLE) & w_legal));
   end

   lsu_load_align u_align (
      .i_rdata   (bus_rdata),
      .i_addr_lo (r_addr_lo),
      .i_funct3  (r_funct3),
      .o_data    (w_load_data)
   );

   // Transaction FSM with registered bus outputs, load result and fault pulses.
   always_ff @(posedge clock) begin
      if (!sync_reset) begin
         r_state        <= IDLE;
         r_cnt          <= '0;
         r_funct3       <= 3'd0;
         r_addr_lo      <= 2'd0;
         r_is_load      <= 1'b0;
         bus_req        <= 1'b0;
         bus_we         <= 1'b0;
         bus_addr       <= 32'd0;
         bus_wdata      <= 32'd0;
         bus_byte_en    <= 4'd0;
         load_data_M    <= 32'd0;
         misaligned_M   <= 1'b0;
         access_fault_M <= 1'b0;
         bus_err_M      <= 1'b0;
      end else begin
         misaligned_M   <= 1'b0;
         access_fault_M <= 1'b0;
         bus_err_M      <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_legal) begin
                  r_state     <= REQ;
                  r_cnt       <= '0;
                  r_funct3    <= funct3_M;
                  r_addr_lo   <= ALU_result_M[1:0];
                  r_is_load   <= mem_read_M;
                  bus_req     <= 1'b1;
                  bus_we      <= mem_write_M;
                  bus_addr    <= {ALU_result_M[31:2], 2'b00};
                  bus_byte_en <= w_lanes[35:32];
                  bus_wdata   <= w_lanes[31:0];
               end else begin
                  access_fault_M <= w_fault;
                  misaligned_M   <= w_misal;
               end
            end
            REQ: begin
               // An ack in the same cycle as the timeout completes normally.
               if (bus_ack) begin
                  r_state <= DONE;
                  bus_req <= 1'b0;
                  if (r_is_load)
                     load_data_M <= w_load_data;
               end else if (w_timeout) begin
                  r_state   <= DONE;
                  bus_req   <= 1'b0;
                  bus_err_M <= 1'b1;
                  if (r_is_load)
                     load_data_M <= 32'd0;
               end else if (r_cnt != {CNT_W{1'b1}}) begin
                  r_cnt <= w_cnt_inc[CNT_W-1:0];
               end
            end
            DONE: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu: directed cases plus
//               randomized accesses against a behavioural lane/extension model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

   localparam int TMO = 8;

   logic        clock = 1'b0;
   logic        sync_reset;
   logic        mem_read_M, mem_write_M;
   logic [2:0]  funct3_M;
   logic [31:0] ALU_result_M, write_data_M;
   logic        bus_req, bus_we;
   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_byte_en;
   logic        bus_ack;
   logic [31:0] bus_rdata;
   logic [31:0] load_data_M;
   logic        stall_M, misaligned_M, access_fault_M, bus_err_M;

   int          n_asserts = 0;
   int          n_fail    = 0;
   logic [31:0] exp_ld    = 32'd0;

   mem_stage_lsu #(.TIMEOUT_CYCLES(TMO)) dut (
      .clock          (clock),
      .sync_reset     (sync_reset),
      .mem_read_M     (mem_read_M),
      .mem_write_M    (mem_write_M),
      .funct3_M       (funct3_M),
      .ALU_result_M   (ALU_result_M),
      .write_data_M   (write_data_M),
      .bus_req        (bus_req),
      .bus_we         (bus_we),
      .bus_addr       (bus_addr),
      .bus_wdata      (bus_wdata),
      .bus_byte_en    (bus_byte_en),
      .bus_ack        (bus_ack),
      .bus_rdata      (bus_rdata),
      .load_data_M    (load_data_M),
      .stall_M        (stall_M),
      .misaligned_M   (misaligned_M),
      .access_fault_M (access_fault_M),
      .bus_err_M      (bus_err_M)
   );

   always #5 clock = ~clock;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int size_bytes(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] addr,
                                           input logic [31:0] rd);
      logic [31:0] b, h;
      b = (rd >> (8 * addr[1:0])) & 32'hFF;
      h = (rd >> (16 * addr[1])) & 32'hFFFF;
      case (f3)
         3'b000:  return (b >= 32'd128) ? b - 32'd256 : b;
         3'b001:  return (h >= 32'd32768) ? h - 32'd65536 : h;
         3'b100:  return b;
         3'b101:  return h;
         default: return rd;
      endcase
   endfunction

   // Runs one M-stage access from IDLE. waits<0 means the slave never acks.
   task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] rdata, input int waits);
      int          sz;
      bit          f3_ok, fault, misal, legal, tmo;
      int          nreq;
      logic [31:0] e_wdata;
      logic [3:0]  e_be;
      sz    = size_bytes(f3);
      f3_ok = wr ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
      fault = (rd && wr) || !f3_ok;
      misal = !fault && ((addr % sz) != 0);
      legal = !fault && !misal;
      if (sz == 1) begin
         e_wdata = (wd & 32'hFF) * 32'h01010101;
         e_be    = 4'(1 << addr[1:0]);
      end else if (sz == 2) begin
         e_wdata = (wd & 32'hFFFF) * 32'h00010001;
         e_be    = (addr[1:0] >= 2) ? 4'b1100 : 4'b0011;
      end else begin
         e_wdata = wd;
         e_be    = 4'b1111;
      end
      mem_read_M   = rd;
      mem_write_M  = wr;
      funct3_M     = f3;
      ALU_result_M = addr;
      write_data_M = wd;
      bus_ack      = 1'b0;
      #1;
      chk("stall_idle", 32'(stall_M), 32'(legal));
      @(posedge clock); #1;
      if (!legal) begin
         chk("noreq_fault", 32'(bus_req), 32'd0);
         chk("fault_pulse", 32'(access_fault_M), 32'(fault));
         chk("misal_pulse", 32'(misaligned_M), 32'(misal));
         mem_read_M  = 1'b0;
         mem_write_M = 1'b0;
         @(posedge clock); #1;
         chk("pulse_clear", {30'd0, access_fault_M, misaligned_M}, 32'd0);
         chk("ld_hold_fault", load_data_M, exp_ld);
         return;
      end
      tmo  = (waits < 0);
      nreq = tmo ? TMO : waits + 1;
      for (int i = 0; i < nreq; i++) begin
         chk("req_hi", 32'(bus_req), 32'd1);
         chk("stall_req", 32'(stall_M), 32'd1);
         chk("req_addr", bus_addr, {addr[31:2], 2'b00});
         chk("req_we", 32'(bus_we), 32'(wr));
         chk("req_be", 32'(bus_byte_en), 32'(e_be));
         if (wr) chk("req_wdata", bus_wdata, e_wdata);
         if (!tmo && i == waits) begin
            bus_ack   = 1'b1;
            bus_rdata = rdata;
         end else begin
            bus_rdata = $urandom;
         end
         @(posedge clock); #1;
         bus_ack = 1'b0;
      end
      if (rd) exp_ld = tmo ? 32'd0 : ref_load(f3, addr, rdata);
      chk("done_req_lo", 32'(bus_req), 32'd0);
      chk("done_stall", 32'(stall_M), 32'd0);
      chk("done_err", 32'(bus_err_M), 32'(tmo));
      chk("done_ld", load_data_M, exp_ld);
      mem_read_M  = 1'b0;
      mem_write_M = 1'b0;
      @(posedge clock); #1;
      chk("idle_err_clr", 32'(bus_err_M), 32'd0);
      chk("idle_req_lo", 32'(bus_req), 32'd0);
   endtask

   initial begin
      sync_reset   = 1'b0;
      mem_read_M   = 1'b0;
      mem_write_M  = 1'b0;
      funct3_M     = 3'd0;
      ALU_result_M = 32'd0;
      write_data_M = 32'd0;
      bus_ack      = 1'b0;
      bus_rdata    = 32'd0;
      repeat (3) @(posedge clock);
      #1;
      // Reset state, including stall held low by an access presented during reset.
      chk("rst_req", 32'(bus_req), 32'd0);
      chk("rst_ld", load_data_M, 32'd0);
      chk("rst_flags", {29'd0, misaligned_M, access_fault_M, bus_err_M}, 32'd0);
      mem_read_M = 1'b1;
      funct3_M   = 3'b010;
      #1;
      chk("rst_stall", 32'(stall_M), 32'd0);
      mem_read_M = 1'b0;
      sync_reset = 1'b1;
      @(posedge clock); #1;

      // Stray ack in IDLE does nothing.
      bus_ack = 1'b1;
      @(posedge clock); #1;
      bus_ack = 1'b0;
      chk("stray_ack_req", 32'(bus_req), 32'd0);
      chk("stray_ack_stall", 32'(stall_M), 32'd0);

      // Directed cases.
      access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80112233, 0);
      chk("lb_sext", load_data_M, 32'hFFFFFF80);
      access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000BEEF, 32'h0, 0);
      chk("sh_keeps_ld", load_data_M, 32'hFFFFFF80);
      access(1'b1, 1'b0, 3'b010, 32'h301, 32'h0, 32'h0, 0);
      access(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 32'h0000F00D, 4);
      chk("lhu_val", load_data_M, 32'h0000F00D);
      access(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 32'h0, -1);
      access(1'b1, 1'b0, 3'b000, 32'h44, 32'h0, 32'h0000007F, TMO - 1);
      access(1'b1, 1'b1, 3'b010, 32'h301, 32'h0, 32'h0, 0);
      access(1'b0, 1'b1, 3'b100, 32'h80, 32'h12345678, 32'h0, 0);
      access(1'b1, 1'b0, 3'b011, 32'h80, 32'h0, 32'h0, 0);
      access(1'b0, 1'b1, 3'b000, 32'h87, 32'hA5A5A5C3, 32'h0, 2);

      // Reset while a request is outstanding; a late ack must be ignored.
      mem_read_M   = 1'b1;
      funct3_M     = 3'b010;
      ALU_result_M = 32'h500;
      @(posedge clock); #1;
      @(posedge clock); #1;
      chk("mid_req_hi", 32'(bus_req), 32'd1);
      sync_reset = 1'b0;
      mem_read_M = 1'b0;
      @(posedge clock); #1;
      chk("rstreq_req", 32'(bus_req), 32'd0);
      chk("rstreq_stall", 32'(stall_M), 32'd0);
      exp_ld = 32'd0;
      chk("rstreq_ld", load_data_M, exp_ld);
      sync_reset = 1'b1;
      bus_ack    = 1'b1;
      bus_rdata  = 32'hDEADBEEF;
      @(posedge clock); #1;
      bus_ack = 1'b0;
      chk("late_ack_req", 32'(bus_req), 32'd0);
      chk("late_ack_ld", load_data_M, exp_ld);
      chk("late_ack_stall", 32'(stall_M), 32'd0);

      // Randomized accesses.
      for (int n = 0; n < 40; n++) begin
         logic rd, wr;
         rd = 1'($urandom_range(0, 1));
         wr = (!rd) ? 1'b1 : ($urandom_range(0, 7) == 0);
         access(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                int'($urandom_range(0, 5)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
